alarm_ctrl: RTL and testbench

Alarm controller that sits directly downstream of the time-of-day counter. It consumes the counter's packed BCD `out_time` bus, compares it against a user-loaded alarm time, and drives a ring output. The ring lasts a bounded time and supports a limited number of fixed-length snoozes. Its `ring` output feeds the buzzer driver, and its status outputs feed the display block.

---
 rtl/alarm_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares the packed BCD time-of-day against a stored
// alarm time, rings for a bounded number of seconds and supports a limited
// number of fixed-length snoozes.
module alarm_ctrl #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] time_in,
  input  logic [12:0] alarm_in,
  input  logic        alarm_load,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic        ring,
  output logic [12:0] alarm_time,
  output logic        load_err,
  output logic [1:0]  snooze_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRing   = 2'b01,
    StSnooze = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] time_q;
  logic [12:0] alarm_time_q, alarm_time_d;
  logic [12:0] wake_time_q, wake_time_d;
  logic [7:0]  ring_sec_q, ring_sec_d;
  logic [1:0]  snooze_cnt_q, snooze_cnt_d;
  logic        load_err_q, load_err_d;
  logic        ring_q;
  logic        snooze_q, stop_q;

  logic tick, snooze_edge, stop_edge;
  logic match_alarm, match_wake;

  // A change of the sampled time marks a new second.
  assign tick        = (time_in != time_q);
  assign snooze_edge = snooze & ~snooze_q;
  assign stop_edge   = stop & ~stop_q;

  assign match_alarm = tick && (time_in[6:0] == 7'd0) && (time_in[19:7] == alarm_time_q);
  assign match_wake  = tick && (time_in[6:0] == 7'd0) && (time_in[19:7] == wake_time_q);

  // Load validation: HH <= 23, MM <= 59, every digit a legal BCD digit.
  logic [1:0] ain_h10;
  logic [3:0] ain_h1;
  logic [2:0] ain_m10;
  logic [3:0] ain_m1;
  logic       ain_valid;

  assign ain_h10 = alarm_in[12:11];
  assign ain_h1  = alarm_in[10:7];
  assign ain_m10 = alarm_in[6:4];
  assign ain_m1  = alarm_in[3:0];

  assign ain_valid = (((ain_h10 < 2'd2) && (ain_h1 <= 4'd9)) ||
                      ((ain_h10 == 2'd2) && (ain_h1 <= 4'd3))) &&
                     (ain_m10 <= 3'd5) && (ain_m1 <= 4'd9);

  // Snooze wake time: current HH:MM plus SNOOZE_MIN minutes, in BCD.
  logic [4:0]  m1_sum;
  logic [3:0]  m10_sum;
  logic        m1_carry, m10_carry;
  logic [3:0]  wake_m1;
  logic [2:0]  wake_m10;
  logic [1:0]  wake_h10;
  logic [3:0]  wake_h1;
  logic [12:0] wake_calc;

  assign m1_sum = {1'b0, time_in[10:7]} + 5'(SNOOZE_MIN);

  // BCD minute/hour carry chain.
  always_comb begin
    m1_carry  = 1'b0;
    m10_carry = 1'b0;
    wake_m1   = m1_sum[3:0];
    wake_h10  = time_in[19:18];
    wake_h1   = time_in[17:14];
    if (m1_sum > 5'd9) begin
      wake_m1  = 4'(m1_sum - 5'd10);
      m1_carry = 1'b1;
    end
    m10_sum  = {1'b0, time_in[13:11]} + {3'b000, m1_carry};
    wake_m10 = m10_sum[2:0];
    if (m10_sum > 4'd5) begin
      wake_m10  = 3'd0;
      m10_carry = 1'b1;
    end
    if (m10_carry) begin
      if ((time_in[19:18] == 2'd2) && (time_in[17:14] == 4'd3)) begin
        wake_h10 = 2'd0;
        wake_h1  = 4'd0;
      end else if (time_in[17:14] == 4'd9) begin
        wake_h10 = time_in[19:18] + 2'd1;
        wake_h1  = 4'd0;
      end else begin
        wake_h1 = time_in[17:14] + 4'd1;
      end
    end
    wake_calc = {wake_h10, wake_h1, wake_m10, wake_m1};
  end

  // Alarm load handling, independent of the ring/snooze state.
  always_comb begin
    alarm_time_d = alarm_time_q;
    load_err_d   = 1'b0;
    if (alarm_load) begin
      if (ain_valid) alarm_time_d = alarm_in;
      else           load_err_d   = 1'b1;
    end
  end

  // Next-state logic for the ring/snooze FSM.
  always_comb begin
    state_d      = state_q;
    ring_sec_d   = ring_sec_q;
    snooze_cnt_d = snooze_cnt_q;
    wake_time_d  = wake_time_q;
    if (!alarm_en) begin
      state_d      = StIdle;
      snooze_cnt_d = 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match_alarm) begin
            state_d    = StRing;
            ring_sec_d = 8'd0;
          end
        end
        StRing: begin
          if (stop_edge) begin
            state_d      = StIdle;
            snooze_cnt_d = 2'd0;
          end else if (snooze_edge && ({30'd0, snooze_cnt_q} < MAX_SNOOZE)) begin
            state_d      = StSnooze;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
            wake_time_d  = wake_calc;
          end else if (tick) begin
            // A snooze press past the limit falls through to normal timing.
            if (ring_sec_q == 8'(RING_SECS - 1)) begin
              state_d      = StIdle;
              snooze_cnt_d = 2'd0;
            end else begin
              ring_sec_d = ring_sec_q + 8'd1;
            end
          end
        end
        StSnooze: begin
          if (stop_edge) begin
            state_d      = StIdle;
            snooze_cnt_d = 2'd0;
          end else if (match_wake) begin
            state_d    = StRing;
            ring_sec_d = 8'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      time_q       <= 20'd0;
      alarm_time_q <= 13'd0;
      wake_time_q  <= 13'd0;
      ring_sec_q   <= 8'd0;
      snooze_cnt_q <= 2'd0;
      load_err_q   <= 1'b0;
      ring_q       <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_in;
      alarm_time_q <= alarm_time_d;
      wake_time_q  <= wake_time_d;
      ring_sec_q   <= ring_sec_d;
      snooze_cnt_q <= snooze_cnt_d;
      load_err_q   <= load_err_d;
      ring_q       <= (state_d == StRing);
      snooze_q     <= snooze;
      stop_q       <= stop;
    end
  end

  assign ring       = ring_q;
  assign alarm_time = alarm_time_q;
  assign load_err   = load_err_q;
  assign snooze_cnt = snooze_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: a vector table for loads and the first
// ring, plus directed sequences for timing-heavy corner cases.
module tb_alarm_ctrl;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RNG  = 2'b01;
  localparam logic [1:0] SNZ  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] time_in;
  logic [12:0] alarm_in;
  logic        alarm_load, alarm_en, snooze, stop;
  logic        ring, load_err;
  logic [12:0] alarm_time;
  logic [1:0]  snooze_cnt, state;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_ctrl #(
    .RING_SECS (60),
    .SNOOZE_MIN(5),
    .MAX_SNOOZE(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_in   (time_in),
    .alarm_in  (alarm_in),
    .alarm_load(alarm_load),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .stop      (stop),
    .ring      (ring),
    .alarm_time(alarm_time),
    .load_err  (load_err),
    .snooze_cnt(snooze_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] tm;
    logic [12:0] ain;
    logic        ld;
    logic        en;
    logic        ring;
    logic [1:0]  st;
    logic [1:0]  cnt;
    logic        lerr;
    logic [12:0] atime;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] t(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [12:0] hm(int h, int m);
    logic [19:0] r;
    r = t(h, m, 0);
    return r[19:7];
  endfunction

  function automatic vec_t mk(logic [19:0] tm, logic [12:0] ain, logic ld, logic r,
                              logic [1:0] st, logic [1:0] cnt, logic lerr,
                              logic [12:0] atime);
    vec_t v;
    v.tm = tm; v.ain = ain; v.ld = ld; v.en = 1'b1; v.ring = r; v.st = st;
    v.cnt = cnt; v.lerr = lerr; v.atime = atime;
    return v;
  endfunction

  task automatic cmp1(input string n, input logic a, input logic e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", n, a, e);
    end
  endtask

  task automatic cmp2(input string n, input logic [1:0] a, input logic [1:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic cmp13(input string n, input logic [12:0] a, input logic [12:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic expect_st(input string n, input logic r, input logic [1:0] st,
                           input logic [1:0] cnt);
    cmp1({n, " ring"}, ring, r);
    cmp2({n, " state"}, state, st);
    cmp2({n, " snooze_cnt"}, snooze_cnt, cnt);
  endtask

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic cyc(input logic [19:0] tm, input logic snz, input logic stp);
    time_in = tm;
    snooze  = snz;
    stop    = stp;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [19:0] tm, input logic [12:0] ain);
    alarm_in   = ain;
    alarm_load = 1'b1;
    cyc(tm, 1'b0, 1'b0);
    alarm_load = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    time_in    = '0;
    alarm_in   = '0;
    alarm_load = 1'b0;
    alarm_en   = 1'b1;
    snooze     = 1'b0;
    stop       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 1'b0, IDLE, 2'd0);
    cmp13("reset alarm_time", alarm_time, 13'd0);
    cmp1("reset load_err", load_err, 1'b0);
    rst = 1'b0;
    // Counter at 00:00:00 with alarm 00:00: no tick, so no ring.
    cyc(t(0, 0, 0), 1'b0, 1'b0);
    cmp1("no fire at reset", ring, 1'b0);

    // Loads (valid, then two invalid), then the first ring.
    vecs.push_back(mk(t(0, 0, 0),   hm(6, 30),  1'b1, 1'b0, IDLE, 2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(0, 0, 0),   hm(24, 0),  1'b1, 1'b0, IDLE, 2'd0, 1'b1, hm(6, 30)));
    vecs.push_back(mk(t(0, 0, 0),   hm(24, 0),  1'b0, 1'b0, IDLE, 2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(0, 0, 0),   hm(12, 60), 1'b1, 1'b0, IDLE, 2'd0, 1'b1, hm(6, 30)));
    vecs.push_back(mk(t(0, 0, 0),   hm(12, 60), 1'b0, 1'b0, IDLE, 2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(6, 29, 58), hm(0, 0),   1'b0, 1'b0, IDLE, 2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(6, 29, 59), hm(0, 0),   1'b0, 1'b0, IDLE, 2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(6, 30, 0),  hm(0, 0),   1'b0, 1'b1, RNG,  2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(6, 30, 0),  hm(0, 0),   1'b0, 1'b1, RNG,  2'd0, 1'b0, hm(6, 30)));
    vecs.push_back(mk(t(6, 30, 1),  hm(0, 0),   1'b0, 1'b1, RNG,  2'd0, 1'b0, hm(6, 30)));

    for (int i = 0; i < vecs.size(); i++) begin
      string n;
      n = $sformatf("vec%0d", i);
      time_in    = vecs[i].tm;
      alarm_in   = vecs[i].ain;
      alarm_load = vecs[i].ld;
      alarm_en   = vecs[i].en;
      @(posedge clk);
      #1;
      expect_st(n, vecs[i].ring, vecs[i].st, vecs[i].cnt);
      cmp1({n, " load_err"}, load_err, vecs[i].lerr);
      cmp13({n, " alarm_time"}, alarm_time, vecs[i].atime);
    end
    alarm_load = 1'b0;

    // Auto-off after 60 ticks in total.
    for (int s = 2; s < 60; s++) begin
      cyc(t(6, 30, s), 1'b0, 1'b0);
      cmp1($sformatf("ringing 06:30:%0d", s), ring, 1'b1);
    end
    cyc(t(6, 31, 0), 1'b0, 1'b0);
    expect_st("auto-off", 1'b0, IDLE, 2'd0);

    // Snooze across midnight: 23:58 + 5 min -> 00:03.
    load(t(23, 57, 59), hm(23, 58));
    cmp13("load 23:58", alarm_time, hm(23, 58));
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    expect_st("ring 23:58", 1'b1, RNG, 2'd0);
    cyc(t(23, 58, 10), 1'b1, 1'b0);
    expect_st("snooze1", 1'b0, SNZ, 2'd1);
    cyc(t(23, 59, 0), 1'b0, 1'b0);
    cyc(t(0, 0, 0), 1'b0, 1'b0);
    cyc(t(0, 2, 59), 1'b0, 1'b0);
    expect_st("snoozing 00:02:59", 1'b0, SNZ, 2'd1);
    cyc(t(0, 3, 0), 1'b0, 1'b0);
    expect_st("wake 00:03", 1'b1, RNG, 2'd1);
    cyc(t(0, 3, 5), 1'b0, 1'b1);
    expect_st("stop", 1'b0, IDLE, 2'd0);
    cyc(t(0, 3, 6), 1'b0, 1'b0);

    // Snooze limit: three snoozes, the fourth press is ignored.
    cyc(t(23, 57, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 1), 1'b1, 1'b0);
    cyc(t(23, 58, 2), 1'b0, 1'b0);
    cyc(t(0, 3, 0), 1'b0, 1'b0);
    cyc(t(0, 3, 1), 1'b1, 1'b0);
    expect_st("limit snooze2", 1'b0, SNZ, 2'd2);
    cyc(t(0, 3, 2), 1'b0, 1'b0);
    cyc(t(0, 8, 0), 1'b0, 1'b0);
    expect_st("limit wake2", 1'b1, RNG, 2'd2);
    cyc(t(0, 8, 1), 1'b1, 1'b0);
    cyc(t(0, 8, 2), 1'b0, 1'b0);
    cyc(t(0, 13, 0), 1'b0, 1'b0);
    expect_st("limit wake3", 1'b1, RNG, 2'd3);
    cyc(t(0, 13, 1), 1'b1, 1'b0);
    expect_st("snooze4 ignored", 1'b1, RNG, 2'd3);
    cyc(t(0, 13, 2), 1'b0, 1'b0);
    cyc(t(0, 13, 3), 1'b0, 1'b1);
    expect_st("limit stop", 1'b0, IDLE, 2'd0);

    // Holding a matching time after stop must not re-trigger.
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cmp1("ring again", ring, 1'b1);
    cyc(t(23, 58, 0), 1'b0, 1'b1);
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    expect_st("hold no retrigger", 1'b0, IDLE, 2'd0);

    // Simultaneous stop and snooze: stop wins.
    cyc(t(23, 57, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 1), 1'b1, 1'b0);
    cyc(t(23, 58, 2), 1'b0, 1'b0);
    cyc(t(0, 3, 0), 1'b0, 1'b0);
    expect_st("prio ring cnt1", 1'b1, RNG, 2'd1);
    cyc(t(0, 3, 1), 1'b1, 1'b1);
    expect_st("stop beats snooze", 1'b0, IDLE, 2'd0);
    cyc(t(0, 3, 2), 1'b0, 1'b0);

    // alarm_en low during SNOOZE cancels the pending wake.
    cyc(t(23, 57, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 1), 1'b1, 1'b0);
    expect_st("en test snooze", 1'b0, SNZ, 2'd1);
    alarm_en = 1'b0;
    cyc(t(23, 58, 2), 1'b0, 1'b0);
    expect_st("en low", 1'b0, IDLE, 2'd0);
    alarm_en = 1'b1;
    cyc(t(0, 3, 0), 1'b0, 1'b0);
    expect_st("no wake after en low", 1'b0, IDLE, 2'd0);

    // alarm_en low during RING drops ring on the next edge.
    cyc(t(23, 57, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cmp1("ring before en low", ring, 1'b1);
    alarm_en = 1'b0;
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    expect_st("en low in ring", 1'b0, IDLE, 2'd0);
    alarm_en = 1'b1;

    // Asynchronous reset while ringing.
    cyc(t(23, 57, 0), 1'b0, 1'b0);
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cmp1("ring before rst", ring, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    expect_st("async rst", 1'b0, IDLE, 2'd0);
    cmp13("async rst alarm_time", alarm_time, 13'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(t(23, 58, 0), 1'b0, 1'b0);
    cmp1("after rst no ring", ring, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
